// File: rtl/icache_direct_if.sv
// Fetch and memory-refill signals of the instruction cache.
// The cache uses the slave modport; fetch stage and memory controller use master.
interface icache_direct_if;
    logic        pc_valid;
    logic [31:0] pc_in;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  pc_valid, pc_in, mem_resp_valid, mem_resp_data,
        output inst_ready, inst_out, mem_req_valid, mem_addr
    );

    modport master (
        output pc_valid, pc_in, mem_resp_valid, mem_resp_data,
        input  inst_ready, inst_out, mem_req_valid, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with whole-line refill and fetch kill.
// state  | meaning
// IDLE   | accept lookups; hit answers next cycle, miss starts a refill
// REFILL | fetching line words in order; clr only marks the delivery as killed
module icache_direct #(
    parameter int INDEX_BITS       = 8,
    parameter int OFFSET_WORDS_LOG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clr,
    icache_direct_if.slave bus
);
    localparam int OWL      = OFFSET_WORDS_LOG;
    localparam int IB       = INDEX_BITS;
    localparam int LINES    = 1 << IB;
    localparam int WORDS    = 1 << OWL;
    localparam int TAG_LSB  = 2 + OWL + IB;
    localparam int TAG_BITS = 32 - TAG_LSB;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t               state_q, state_d;
    logic                 kill_q, kill_d;
    logic [OWL-1:0]       cnt_q, cnt_d;
    logic [IB-1:0]        req_index_q, req_index_d;
    logic [TAG_BITS-1:0]  req_tag_q, req_tag_d;
    logic [OWL-1:0]       req_offset_q, req_offset_d;
    logic                 inst_ready_q, inst_ready_d;
    logic [31:0]          inst_out_q, inst_out_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    logic [31:0]          mem_addr_q, mem_addr_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [31:0]          data_q [LINES*WORDS];

    logic [OWL-1:0]       pc_offset;
    logic [IB-1:0]        pc_index;
    logic [TAG_BITS-1:0]  pc_tag;
    logic                 hit;
    logic [OWL-1:0]       cnt_inc;
    logic                 fill_we, fill_done, miss_start;
    logic                 unused_pc_low;

    assign pc_offset     = bus.pc_in[2+OWL-1:2];
    assign pc_index      = bus.pc_in[TAG_LSB-1:2+OWL];
    assign pc_tag        = bus.pc_in[31:TAG_LSB];
    assign unused_pc_low = ^bus.pc_in[1:0];
    assign hit           = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign cnt_inc       = cnt_q + OWL'(1);

    always_comb begin
        state_d         = state_q;
        kill_d          = kill_q;
        cnt_d           = cnt_q;
        req_index_d     = req_index_q;
        req_tag_d       = req_tag_q;
        req_offset_d    = req_offset_q;
        inst_ready_d    = 1'b0;
        inst_out_d      = inst_out_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        fill_we         = 1'b0;
        fill_done       = 1'b0;
        miss_start      = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    // The inst_ready gap stops a second delivery while IF drops pc_valid.
                    if (bus.pc_valid && !clr && !inst_ready_q) begin
                        if (hit) begin
                            inst_ready_d = 1'b1;
                            inst_out_d   = data_q[{pc_index, pc_offset}];
                        end else begin
                            miss_start      = 1'b1;
                            state_d         = REFILL;
                            mem_req_valid_d = 1'b1;
                            mem_addr_d      = {pc_tag, pc_index, {(OWL+2){1'b0}}};
                            cnt_d           = '0;
                            req_index_d     = pc_index;
                            req_tag_d       = pc_tag;
                            req_offset_d    = pc_offset;
                        end
                    end
                end
                REFILL: begin
                    if (clr) kill_d = 1'b1;
                    if (bus.mem_resp_valid) begin
                        fill_we = 1'b1;
                        if (!(&cnt_q)) begin
                            cnt_d      = cnt_inc;
                            mem_addr_d = {req_tag_q, req_index_q, cnt_inc, 2'b00};
                        end else begin
                            fill_done       = 1'b1;
                            mem_req_valid_d = 1'b0;
                            state_d         = IDLE;
                            kill_d          = 1'b0;
                            cnt_d           = '0;
                            if (!kill_q && !clr) begin
                                inst_ready_d = 1'b1;
                                // Requested word is either already buffered or arriving now.
                                inst_out_d   = (req_offset_q == cnt_q) ? bus.mem_resp_data
                                                                       : data_q[{req_index_q, req_offset_q}];
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            kill_q          <= 1'b0;
            cnt_q           <= '0;
            req_index_q     <= '0;
            req_tag_q       <= '0;
            req_offset_q    <= '0;
            inst_ready_q    <= 1'b0;
            inst_out_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            kill_q          <= kill_d;
            cnt_q           <= cnt_d;
            req_index_q     <= req_index_d;
            req_tag_q       <= req_tag_d;
            req_offset_q    <= req_offset_d;
            inst_ready_q    <= inst_ready_d;
            inst_out_q      <= inst_out_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
        end
    end

    // A line being refilled is invalid until its last word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (miss_start) begin
            valid_q[pc_index] <= 1'b0;
        end else if (fill_done) begin
            valid_q[req_index_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_we) data_q[{req_index_q, cnt_q}] <= bus.mem_resp_data;
        if (!rst && fill_done) tag_q[req_index_q] <= req_tag_q;
    end

    assign bus.inst_ready    = inst_ready_q;
    assign bus.inst_out      = inst_out_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct against a line-presence model of the cache.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst, rdy, clr;
    int   n_total = 0;
    int   n_bad   = 0;

    bit          m_valid [256];
    logic [19:0] m_tag   [256];

    icache_direct_if bus ();

    icache_direct #(.INDEX_BITS(8), .OFFSET_WORDS_LOG(2)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    // kill_after: -1 for a normal fetch, otherwise clr is pulsed after that response index
    task automatic fetch(input logic [31:0] pc, input int kill_after);
        logic [31:0] base;
        logic [31:0] pcw;
        int          idx;
        bit          killed;
        int          gap;
        base   = {pc[31:4], 4'b0000};
        pcw    = {pc[31:2], 2'b00};
        idx    = int'(pc[11:4]);
        killed = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_in    = pc;
        @(negedge clk);
        if (m_valid[idx] && m_tag[idx] == pc[31:12]) begin
            chk("hit_ready", bus.inst_ready, 1);
            chk("hit_data", bus.inst_out, memword(pcw));
            chk("hit_noreq", bus.mem_req_valid, 0);
            bus.pc_valid = 1'b0;
            @(negedge clk);
            chk("hit_pulse", bus.inst_ready, 0);
            return;
        end
        chk("miss_req", bus.mem_req_valid, 1);
        chk("miss_noready", bus.inst_ready, 0);
        for (int w = 0; w < 4; w++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                rdy = ($urandom_range(0, 1) == 0);
                @(negedge clk);
                chk("refill_hold", bus.mem_req_valid, 1);
                chk("refill_noready", bus.inst_ready, 0);
            end
            rdy = 1'b1;
            chk("refill_addr", bus.mem_addr, base + 32'(4 * w));
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = memword(base + 32'(4 * w));
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = $urandom;
            if (w < 3) begin
                chk("refill_noready", bus.inst_ready, 0);
                chk("refill_req", bus.mem_req_valid, 1);
            end
            if (w == kill_after) begin
                clr          = 1'b1;
                bus.pc_valid = 1'b0;
                killed       = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                chk("kill_req", bus.mem_req_valid, 1);
                chk("kill_noready", bus.inst_ready, 0);
            end
        end
        chk("fill_ready", bus.inst_ready, killed ? 0 : 1);
        if (!killed) chk("fill_data", bus.inst_out, memword(pcw));
        chk("fill_reqdrop", bus.mem_req_valid, 0);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = pc[31:12];
        bus.pc_valid = 1'b0;
        @(negedge clk);
        chk("fill_pulse", bus.inst_ready, 0);
    endtask

    task automatic clr_lookup(input logic [31:0] pc);
        bus.pc_valid = 1'b1;
        bus.pc_in    = pc;
        clr          = 1'b1;
        @(negedge clk);
        chk("clr_noready", bus.inst_ready, 0);
        chk("clr_noreq", bus.mem_req_valid, 0);
        bus.pc_valid = 1'b0;
        clr          = 1'b0;
        @(negedge clk);
        chk("clr_after", bus.inst_ready, 0);
    endtask

    task automatic held_hit(input logic [31:0] pc);
        bus.pc_valid = 1'b1;
        bus.pc_in    = pc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_pattern", bus.inst_ready, (i == 1) ? 0 : 1);
            chk("held_noreq", bus.mem_req_valid, 0);
        end
        bus.pc_valid = 1'b0;
        @(negedge clk);
        chk("held_end", bus.inst_ready, 0);
    endtask

    initial begin
        logic [31:0] pc;
        int          kind;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        bus.pc_valid = 1'b0; bus.pc_in = '0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.inst_ready, 0);
        chk("rst_out", bus.inst_out, 0);
        chk("rst_req", bus.mem_req_valid, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h0000_0004, -1);
        fetch(32'h0000_0008, -1);
        fetch(32'h0000_1000, -1);
        fetch(32'h0000_0000, -1);
        fetch(32'h0000_0020, 1);
        fetch(32'h0000_0024, -1);
        clr_lookup(32'h0000_0024);
        held_hit(32'h0000_0008);

        for (int it = 0; it < 80; it++) begin
            pc = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            if (kind < 7)       fetch(pc, -1);
            else if (kind < 9)  fetch(pc, int'($urandom_range(0, 2)));
            else                clr_lookup(pc);
        end

        bus.pc_valid = 1'b1;
        bus.pc_in    = 32'h0000_3040;
        @(negedge clk);
        chk("rmid_req", bus.mem_req_valid, 1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = memword(32'h0000_3040);
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.pc_valid       = 1'b0;
        rst                = 1'b1;
        @(negedge clk);
        chk("rmid_req", bus.mem_req_valid, 0);
        chk("rmid_ready", bus.inst_ready, 0);
        chk("rmid_addr", bus.mem_addr, 0);
        chk("rmid_out", bus.inst_out, 0);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        fetch(32'h0000_3048, -1);
        fetch(32'h0000_0008, -1);
        fetch(32'h0000_0008, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
